// File: rtl/pid_spd_ctrl.sv
// pid_spd_ctrl: P+I+D heading correction around a forward speed command.
// Optional derivative path is built only when PID_DTERM_EN is defined.
module pid_spd_ctrl #(
  parameter int unsigned P_COEFF = 5,
  parameter int unsigned D_COEFF = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               moving,
  input  logic               err_vld,
  input  logic signed [11:0] error,
  input  logic        [9:0]  frwrd,
  output logic signed [10:0] lft_spd,
  output logic signed [10:0] rght_spd
);

  localparam logic signed [13:0] PK = 14'(P_COEFF);

  logic signed [9:0]  err_sat;
  logic signed [13:0] es14;
  logic signed [13:0] p_next;
  logic signed [13:0] p_term;
  logic signed [14:0] integ;
  logic signed [14:0] integ_sum;
  logic               integ_ovf;
  logic signed [12:0] d_term;
  logic signed [8:0]  i_term;
  logic signed [14:0] pid;
  logic signed [11:0] corr;
  logic signed [12:0] fw13;
  logic signed [12:0] lsum;
  logic signed [12:0] rsum;
  logic               sample;
  logic               unused_ok;

  function automatic logic signed [10:0] sat11(
    input logic signed [12:0] s
  );
    if (s > 13'sd1023)
      return 11'sd1023;
    else if (s < -13'sd1024)
      return 11'h400;
    else
      return s[10:0];
  endfunction

  // clamp the raw error into the 10-bit working range
  always_comb begin
    if (error > 12'sd511)
      err_sat = 10'sd511;
    else if (error < -12'sd512)
      err_sat = 10'h200;
    else
      err_sat = error[9:0];
  end

  assign sample    = err_vld & moving;
  assign es14      = 14'(err_sat);
  assign p_next    = es14 * PK;
  assign integ_sum = integ + 15'(err_sat);
  assign integ_ovf = (integ[14] == err_sat[9]) &&
                     (integ_sum[14] != integ[14]);

  // stage 1: proportional term and saturating integrator
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_term <= '0;
      integ  <= '0;
    end else if (!moving) begin
      p_term <= '0;
      integ  <= '0;
    end else if (err_vld) begin
      p_term <= p_next;
      if (!integ_ovf)
        integ <= integ_sum;
    end
  end

`ifdef PID_DTERM_EN
  localparam logic signed [12:0] DK = 13'(D_COEFF);

  logic signed [9:0]  prev_err;
  logic signed [10:0] d_raw;
  logic signed [6:0]  d_diff;
  logic signed [12:0] d_next;

  assign d_raw = 11'(err_sat) - 11'(prev_err);

  // clamp the sample-to-sample difference to 7 bits
  always_comb begin
    if (d_raw > 11'sd63)
      d_diff = 7'sd63;
    else if (d_raw < -11'sd64)
      d_diff = 7'h40;
    else
      d_diff = d_raw[6:0];
  end

  assign d_next = 13'(d_diff) * DK;

  // stage 1: derivative term and previous-sample memory
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_term   <= '0;
      prev_err <= '0;
    end else if (!moving) begin
      d_term   <= '0;
      prev_err <= '0;
    end else if (sample) begin
      d_term   <= d_next;
      prev_err <= err_sat;
    end
  end

  assign unused_ok = ^pid[2:0];
`else
  assign d_term    = '0;
  assign unused_ok = ^{pid[2:0], sample, 5'(D_COEFF)};
`endif

  assign i_term = integ[14:6];
  assign pid    = 15'(p_term) + 15'(i_term) + 15'(d_term);
  assign corr   = pid[14:3];
  assign fw13   = {3'b000, frwrd};
  assign lsum   = fw13 + 13'(corr);
  assign rsum   = fw13 - 13'(corr);

  // stage 2: mix correction around forward speed and clamp
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lft_spd  <= '0;
      rght_spd <= '0;
    end else if (!moving) begin
      lft_spd  <= '0;
      rght_spd <= '0;
    end else begin
      lft_spd  <= sat11(lsum);
      rght_spd <= sat11(rsum);
    end
  end

endmodule

// File: tb/tb_pid_spd_ctrl.sv
// tb_pid_spd_ctrl: scoreboard bench for pid_spd_ctrl.
// Integer reference model; define PID_DTERM_EN to match the DUT build.
module tb_pid_spd_ctrl;

  localparam int P = 5;
  localparam int D = 6;

  logic               clk = 1'b0;
  logic               rst;
  logic               moving;
  logic               err_vld;
  logic        [11:0] error;
  logic        [9:0]  frwrd;
  logic signed [10:0] lft_spd;
  logic signed [10:0] rght_spd;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int l;
    int r;
  } exp_t;

  exp_t q[$];

  int m_integ;
  int m_p;
  int m_d;
  int m_prev;

  always #5 clk = ~clk;

  pid_spd_ctrl #(
    .P_COEFF(P),
    .D_COEFF(D)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .moving  (moving),
    .err_vld (err_vld),
    .error   (error),
    .frwrd   (frwrd),
    .lft_spd (lft_spd),
    .rght_spd(rght_spd)
  );

  function automatic int clamp(input int v, input int lo, input int hi);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  // predict the outputs at the coming rising edge, then advance state
  task automatic model_edge();
    exp_t x;
    int   corr;
    int   es;
    int   nw;
    if (rst) begin
      x.l = 0;
      x.r = 0;
      m_integ = 0;
      m_p = 0;
      m_d = 0;
      m_prev = 0;
    end else begin
      corr = (m_p + (m_integ >>> 6) + m_d) >>> 3;
      if (moving) begin
        x.l = clamp(int'(frwrd) + corr, -1024, 1023);
        x.r = clamp(int'(frwrd) - corr, -1024, 1023);
      end else begin
        x.l = 0;
        x.r = 0;
      end
      if (!moving) begin
        m_integ = 0;
        m_p = 0;
        m_d = 0;
        m_prev = 0;
      end else if (err_vld) begin
        es = clamp(int'($signed(error)), -512, 511);
        m_p = es * P;
        nw = m_integ + es;
        if (nw <= 16383 && nw >= -16384)
          m_integ = nw;
`ifdef PID_DTERM_EN
        m_d = clamp(es - m_prev, -64, 63) * D;
        m_prev = es;
`endif
      end
    end
    q.push_back(x);
  endtask

  // called just after a falling edge; returns at the next falling edge
  task automatic cyc(input bit ev, input int e, input int fw, input bit mv);
    err_vld = ev;
    error   = e[11:0];
    frwrd   = fw[9:0];
    moving  = mv;
    model_edge();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("async_rst_lft", int'(lft_spd), 0);
    chk("async_rst_rght", int'(rght_spd), 0);
    model_edge();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // monitor: compare every registered output against the scoreboard
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        chk("sb_lft", int'(lft_spd), x.l);
        chk("sb_rght", int'(rght_spd), x.r);
      end
    end
  end

  initial begin
    int e;
    int sel;
    int wait_cnt;
    rst = 1'b1;
    moving = 1'b0;
    err_vld = 1'b0;
    error = '0;
    frwrd = '0;
    m_integ = 0;
    m_p = 0;
    m_d = 0;
    m_prev = 0;
    model_edge();
    @(negedge clk);
    chk("reset_lft", int'(lft_spd), 0);
    rst = 1'b0;

    cyc(0, 0, 256, 1);
    cyc(1, 100, 256, 1);
    cyc(0, 0, 256, 1);
`ifdef PID_DTERM_EN
    chk("single_lft", int'(lft_spd), 365);
    chk("single_rght", int'(rght_spd), 147);
`else
    chk("single_lft", int'(lft_spd), 318);
    chk("single_rght", int'(rght_spd), 194);
`endif

    do_reset();
    cyc(1, 100, 256, 1);
    cyc(0, 0, 256, 1);
`ifdef PID_DTERM_EN
    chk("post_rst_lft", int'(lft_spd), 365);
`else
    chk("post_rst_lft", int'(lft_spd), 318);
`endif

    do_reset();
    cyc(1, -2048, 512, 1);
    cyc(0, 0, 512, 1);
`ifdef PID_DTERM_EN
    chk("insat_lft", int'(lft_spd), 143);
    chk("insat_rght", int'(rght_spd), 881);
`else
    chk("insat_lft", int'(lft_spd), 191);
    chk("insat_rght", int'(rght_spd), 833);
`endif

    do_reset();
    for (int i = 0; i < 40; i++)
      cyc(1, 2047, 512, 1);
    chk("integ_hold", int'(dut.integ), 16352);

    for (int i = 0; i < 20; i++)
      cyc(1, 511, 1023, 1);
    cyc(0, 0, 1023, 1);
    chk("clamp_lft", int'(lft_spd), 1023);

    cyc(1, 300, 1023, 0);
    chk("drop_lft", int'(lft_spd), 0);
    chk("drop_integ", int'(dut.integ), 0);
    cyc(0, 0, 1023, 0);
    cyc(1, 0, 700, 1);
    cyc(0, 0, 700, 1);
    chk("reen_lft", int'(lft_spd), 700);
    chk("reen_rght", int'(rght_spd), 700);

    for (int i = 0; i < 3000; i++) begin
      if (i % 500 == 499)
        do_reset();
      sel = int'($urandom_range(0, 3));
      if (sel == 0)
        e = ($urandom_range(0, 1) == 1) ? 2047 : -2048;
      else if (sel == 1)
        e = int'($urandom_range(0, 200)) - 100;
      else
        e = int'($urandom_range(0, 4095)) - 2048;
      cyc($urandom_range(0, 1) == 1, e,
          int'($urandom_range(0, 1023)),
          $urandom_range(0, 15) != 0);
    end

    err_vld = 1'b0;
    wait_cnt = 0;
    while (q.size() > 0 && wait_cnt < 10) begin
      @(negedge clk);
      wait_cnt++;
    end
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d left, expected 0", q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
